// File: rtl/noc_pkg.sv
// Shared NoC definitions: default flit field widths, the flit layout and
// helpers that split a router address into its x/y coordinates.
package noc_pkg;

    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_PAYLOAD_W = 24;
    localparam int DEF_FLIT_W    = DEF_ADDR_W + DEF_PAYLOAD_W;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0]    dest;
        logic [DEF_PAYLOAD_W-1:0] payload;
    } flit_t;

    function automatic logic [DEF_ADDR_W/2-1:0] addr_x(input logic [DEF_ADDR_W-1:0] addr);
        return addr[DEF_ADDR_W/2-1:0];
    endfunction

    function automatic logic [DEF_ADDR_W/2-1:0] addr_y(input logic [DEF_ADDR_W-1:0] addr);
        return addr[DEF_ADDR_W-1:DEF_ADDR_W/2];
    endfunction

endpackage

// File: rtl/noc_local_ni_if.sv
// Host-side and router-side handshake signals of the local network interface.
// The slave modport is the NI itself; master is the host/router environment.
interface noc_local_ni_if
    import noc_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int PAYLOAD_W = DEF_PAYLOAD_W
);
    localparam int FLIT_W = ADDR_W + PAYLOAD_W;

    logic                 tx_valid_i;
    logic                 tx_ready_o;
    logic [ADDR_W-1:0]    tx_dest_i;
    logic [PAYLOAD_W-1:0] tx_data_i;

    logic [FLIT_W-1:0]    local_o;
    logic                 valid_l_o;
    logic                 l_credit_i;

    logic [FLIT_W-1:0]    local_i;
    logic                 valid_l_i;
    logic                 l_credit_o;

    logic                 rx_valid_o;
    logic                 rx_ready_i;
    logic [ADDR_W-1:0]    rx_dest_o;
    logic [PAYLOAD_W-1:0] rx_data_o;

    modport slave (
        input  tx_valid_i, tx_dest_i, tx_data_i, l_credit_i,
               local_i, valid_l_i, rx_ready_i,
        output tx_ready_o, local_o, valid_l_o, l_credit_o,
               rx_valid_o, rx_dest_o, rx_data_o
    );

    modport master (
        output tx_valid_i, tx_dest_i, tx_data_i, l_credit_i,
               local_i, valid_l_i, rx_ready_i,
        input  tx_ready_o, local_o, valid_l_o, l_credit_o,
               rx_valid_o, rx_dest_o, rx_data_o
    );

endinterface

// File: rtl/noc_sync_fifo.sv
// Show-ahead synchronous FIFO; the head entry is visible on dout while not empty.
// The caller must not push when full (unless popping) nor pop when empty.
module noc_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // The extra pointer MSB distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                   (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
    assign dout  = mem[rd_ptr[PTR_W-2:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[PTR_W-2:0]] <= din;
    end

endmodule

// File: rtl/noc_local_ni.sv
// Local-port network interface: credit-controlled single-flit injection and a
// buffered ejection path. Optional flit counters are built with NOC_NI_STATS_EN.
module noc_local_ni
    import noc_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int PAYLOAD_W  = DEF_PAYLOAD_W,
    parameter int TX_CREDITS = 4,
    parameter int RX_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] my_addr_i,
    noc_local_ni_if.slave     ni,
    output logic              overflow_o,
    output logic              misroute_o,
    output logic [15:0]       tx_cnt_o,
    output logic [15:0]       rx_cnt_o
);
    localparam int FLIT_W = ADDR_W + PAYLOAD_W;
    localparam int CRED_W = $clog2(TX_CREDITS + 1);

    logic [CRED_W-1:0] credits;
    logic              tx_hs;
    logic              rx_push;
    logic              rx_pop;
    logic              rx_full;
    logic              rx_empty;
    logic [FLIT_W-1:0] rx_head;

    assign ni.tx_ready_o = (credits != '0);
    assign tx_hs         = ni.tx_valid_i && ni.tx_ready_o;

    // A send and a returned credit in the same cycle cancel; returns beyond the
    // router's buffer depth are spurious and ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credits <= CRED_W'(TX_CREDITS);
        end else if (tx_hs && !ni.l_credit_i) begin
            credits <= credits - CRED_W'(1);
        end else if (!tx_hs && ni.l_credit_i && credits != CRED_W'(TX_CREDITS)) begin
            credits <= credits + CRED_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ni.valid_l_o <= 1'b0;
            ni.local_o   <= '0;
        end else begin
            ni.valid_l_o <= tx_hs;
            if (tx_hs) ni.local_o <= {ni.tx_dest_i, ni.tx_data_i};
        end
    end

    // A full FIFO still accepts a flit when the head leaves in the same cycle.
    assign rx_pop  = !rx_empty && ni.rx_ready_i;
    assign rx_push = ni.valid_l_i && (!rx_full || rx_pop);

    noc_sync_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (ni.local_i),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign ni.rx_valid_o = !rx_empty;
    assign ni.rx_dest_o  = rx_head[FLIT_W-1 -: ADDR_W];
    assign ni.rx_data_o  = rx_head[PAYLOAD_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ni.l_credit_o <= 1'b0;
            overflow_o    <= 1'b0;
            misroute_o    <= 1'b0;
        end else begin
            ni.l_credit_o <= rx_pop;
            if (ni.valid_l_i && rx_full && !rx_pop) overflow_o <= 1'b1;
            if (rx_push && ni.local_i[FLIT_W-1 -: ADDR_W] != my_addr_i) misroute_o <= 1'b1;
        end
    end

`ifdef NOC_NI_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_cnt_o <= '0;
            rx_cnt_o <= '0;
        end else begin
            if (tx_hs)   tx_cnt_o <= tx_cnt_o + 16'd1;
            if (rx_push) rx_cnt_o <= rx_cnt_o + 16'd1;
        end
    end
`else
    assign tx_cnt_o = '0;
    assign rx_cnt_o = '0;
`endif

endmodule

// File: tb/tb_noc_local_ni.sv
// Directed plus randomized bench for noc_local_ni against a queue-based model
// of credits, the ejection buffer and the sticky flags.
module tb_noc_local_ni;
    import noc_pkg::*;

    localparam int ADDR_W    = DEF_ADDR_W;
    localparam int PAYLOAD_W = DEF_PAYLOAD_W;
    localparam int FLIT_W    = ADDR_W + PAYLOAD_W;
    localparam int TXC       = 4;
    localparam int RXD       = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] my_addr;
    logic              overflow;
    logic              misroute;
    logic [15:0]       tx_cnt;
    logic [15:0]       rx_cnt;

    noc_local_ni_if #(.ADDR_W(ADDR_W), .PAYLOAD_W(PAYLOAD_W)) ni_if ();

    noc_local_ni #(
        .ADDR_W     (ADDR_W),
        .PAYLOAD_W  (PAYLOAD_W),
        .TX_CREDITS (TXC),
        .RX_DEPTH   (RXD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .my_addr_i  (my_addr),
        .ni         (ni_if),
        .overflow_o (overflow),
        .misroute_o (misroute),
        .tx_cnt_o   (tx_cnt),
        .rx_cnt_o   (rx_cnt)
    );

    always #5 clk = ~clk;

    int                n_cmp = 0;
    int                n_fail = 0;
    int                credits;
    logic [FLIT_W-1:0] rx_q [$];
    logic              exp_valid_l;
    logic [FLIT_W-1:0] exp_local;
    logic              exp_lcredit;
    logic              exp_ovf;
    logic              exp_mis;
    logic [15:0]       exp_tx_cnt;
    logic [15:0]       exp_rx_cnt;

    task automatic checkOne(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        credits     = TXC;
        rx_q.delete();
        exp_valid_l = 1'b0;
        exp_local   = '0;
        exp_lcredit = 1'b0;
        exp_ovf     = 1'b0;
        exp_mis     = 1'b0;
        exp_tx_cnt  = '0;
        exp_rx_cnt  = '0;
    endtask

    task automatic applyStimulus(input logic txv, input logic [ADDR_W-1:0] dest,
                                 input logic [PAYLOAD_W-1:0] data, input logic lcr,
                                 input logic vli, input logic [FLIT_W-1:0] li,
                                 input logic rxr);
        ni_if.tx_valid_i = txv;
        ni_if.tx_dest_i  = dest;
        ni_if.tx_data_i  = data;
        ni_if.l_credit_i = lcr;
        ni_if.valid_l_i  = vli;
        ni_if.local_i    = li;
        ni_if.rx_ready_i = rxr;
    endtask

    task automatic checkOutput();
        logic [FLIT_W-1:0] head;
        checkOne("tx_ready", ni_if.tx_ready_o, credits != 0);
        checkOne("valid_l", ni_if.valid_l_o, exp_valid_l);
        checkOne("local", ni_if.local_o, exp_local);
        checkOne("l_credit", ni_if.l_credit_o, exp_lcredit);
        checkOne("rx_valid", ni_if.rx_valid_o, rx_q.size() != 0);
        if (rx_q.size() != 0) begin
            head = rx_q[0];
            checkOne("rx_dest", ni_if.rx_dest_o, head[FLIT_W-1 -: ADDR_W]);
            checkOne("rx_data", ni_if.rx_data_o, head[PAYLOAD_W-1:0]);
        end
        checkOne("overflow", overflow, exp_ovf);
        checkOne("misroute", misroute, exp_mis);
`ifdef NOC_NI_STATS_EN
        checkOne("tx_cnt", tx_cnt, exp_tx_cnt);
        checkOne("rx_cnt", rx_cnt, exp_rx_cnt);
`else
        checkOne("tx_cnt_tied", tx_cnt, 16'h0);
        checkOne("rx_cnt_tied", rx_cnt, 16'h0);
`endif
    endtask

    task automatic modelStep();
        bit hs;
        bit pop;
        bit acc;
        hs  = ni_if.tx_valid_i && (credits != 0);
        pop = (rx_q.size() != 0) && ni_if.rx_ready_i;
        acc = ni_if.valid_l_i && ((rx_q.size() < RXD) || pop);
        if (ni_if.valid_l_i && !acc) exp_ovf = 1'b1;
        exp_valid_l = hs;
        if (hs) exp_local = {ni_if.tx_dest_i, ni_if.tx_data_i};
        if (hs && !ni_if.l_credit_i) credits--;
        else if (!hs && ni_if.l_credit_i && credits < TXC) credits++;
        exp_lcredit = pop;
        if (pop) void'(rx_q.pop_front());
        if (acc) begin
            rx_q.push_back(ni_if.local_i);
            if (ni_if.local_i[FLIT_W-1 -: ADDR_W] != my_addr) exp_mis = 1'b1;
        end
        if (hs)  exp_tx_cnt = exp_tx_cnt + 16'd1;
        if (acc) exp_rx_cnt = exp_rx_cnt + 16'd1;
    endtask

    task automatic cycle();
        checkOutput();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        flit_t f;

        my_addr = 8'h11;
        applyStimulus(0, '0, '0, 0, 0, '0, 0);
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        rst = 1'b1;

        // Burst of sends with no returned credits: exactly TXC flits leave.
        applyStimulus(1, 8'h21, 24'hABCDEF, 0, 0, '0, 0);
        pulses = 0;
        pulses += int'(ni_if.valid_l_o);
        cycle();
        checkOne("flit_0x21", ni_if.local_o, 32'h21ABCDEF);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 8'(8'h30 + i), 24'($urandom), 0, 0, '0, 0);
            pulses += int'(ni_if.valid_l_o);
            cycle();
        end
        applyStimulus(0, '0, '0, 0, 0, '0, 0);
        pulses += int'(ni_if.valid_l_o);
        cycle();
        checkOne("burst_pulses", pulses, 4);
        checkOne("ready_low_at_0", ni_if.tx_ready_o, 1'b0);

        applyStimulus(0, '0, '0, 1, 0, '0, 0);
        cycle();
        checkOne("ready_after_credit", ni_if.tx_ready_o, 1'b1);
        applyStimulus(1, 8'h42, 24'h123456, 0, 0, '0, 0);
        cycle();
        applyStimulus(0, '0, '0, 0, 0, '0, 0);
        cycle();

        // Bring credits to 2, then send and return in the same cycle.
        repeat (2) begin
            applyStimulus(0, '0, '0, 1, 0, '0, 0);
            cycle();
        end
        applyStimulus(1, 8'h05, 24'h000777, 1, 0, '0, 0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 8'(i), 24'($urandom), 0, 0, '0, 0);
            cycle();
        end
        repeat (6) begin
            applyStimulus(0, '0, '0, 1, 0, '0, 0);
            cycle();
        end
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 8'(8'h60 + i), 24'($urandom), 0, 0, '0, 0);
            cycle();
        end
        repeat (4) begin
            applyStimulus(0, '0, '0, 1, 0, '0, 0);
            cycle();
        end

        // Fill the ejection FIFO, push into full with and without a pop.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, '0, '0, 0, 1, {my_addr, 24'($urandom)}, 0);
            cycle();
        end
        applyStimulus(0, '0, '0, 0, 1, {my_addr, 24'h555555}, 1);
        cycle();
        checkOne("full_push_pop_ovf", overflow, 1'b0);
        applyStimulus(0, '0, '0, 0, 1, {my_addr, 24'h666666}, 0);
        cycle();
        checkOne("full_push_drop_ovf", overflow, 1'b1);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, '0, '0, 0, 0, '0, 1);
            pulses += int'(ni_if.l_credit_o);
            cycle();
        end
        checkOne("drain_credit_pulses", pulses, 4);

        // Misrouted flit is still delivered; reset clears everything at once.
        applyStimulus(0, '0, '0, 0, 1, {8'h12, 24'hC0FFEE}, 0);
        cycle();
        checkOne("misroute_set", misroute, 1'b1);
        checkOne("misroute_dest", ni_if.rx_dest_o, 8'h12);
        applyStimulus(0, '0, '0, 0, 0, '0, 0);
        #2;
        rst = 1'b0;
        #1;
        checkOne("async_rst_misroute", misroute, 1'b0);
        checkOne("async_rst_rx_valid", ni_if.rx_valid_o, 1'b0);
        checkOne("async_rst_overflow", overflow, 1'b0);
        modelReset();
        @(posedge clk);
        #1;
        checkOutput();
        rst = 1'b1;

        for (int i = 0; i < 400; i++) begin
            f.dest    = ($urandom_range(0, 3) != 0) ? my_addr : 8'($urandom);
            f.payload = 24'($urandom);
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 24'($urandom),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f,
                          1'($urandom_range(0, 2) != 0));
            cycle();
        end

`ifdef NOC_NI_STATS_EN
        applyStimulus(0, '0, '0, 0, 0, '0, 0);
        rst = 1'b0;
        #1;
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 8'h21, 24'($urandom), 0, (i < 2), {my_addr, 24'($urandom)}, 0);
            cycle();
        end
        applyStimulus(0, '0, '0, 0, 0, '0, 0);
        cycle();
        checkOne("stats_tx3", tx_cnt, 16'd3);
        checkOne("stats_rx2", rx_cnt, 16'd2);
        for (int i = 0; i < 70000 && exp_tx_cnt != 16'hFFFF; i++) begin
            applyStimulus(1, 8'h21, 24'h0, 1, 0, '0, 1);
            cycle();
        end
        checkOne("stats_preload", tx_cnt, 16'hFFFF);
        applyStimulus(1, 8'h21, 24'h0, 1, 0, '0, 0);
        cycle();
        checkOne("stats_wrap", tx_cnt, 16'h0);
`endif

        applyStimulus(0, '0, '0, 0, 0, '0, 0);
        cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
